// File: rtl/vga_pkg.sv
// Shared timing, colour and cell-geometry constants for the data-memory
// VGA debug window.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CELL    = 16;

    localparam logic [23:0] COL_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
    localparam logic [23:0] COL_BG     = 24'h000040;

endpackage

// File: rtl/hex_font_rom.sv
// 8x8 hex-digit font, one registered glyph row per pixel-enable tick.
// Each glyph is packed top row first, MSB = leftmost pixel.
module hex_font_rom (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic [3:0] nib_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    localparam logic [63:0] FONT [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00,
        64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000,
        64'h3C66663C66663C00, 64'h3C66663E060C3800,
        64'h183C66667E666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800,
        64'h7E60607C60607E00, 64'h7E60607C60606000
    };

    logic [63:0] glyph_w;
    logic [7:0]  row_bits_w;

    assign glyph_w    = FONT[nib_i];
    assign row_bits_w = glyph_w[{~row_i, 3'b000} +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i)     bits_o <= '0;
        else if (ce_i) bits_o <= row_bits_w;
    end

endmodule

// File: rtl/vga_mem_display.sv
// Renders N_BYTES memory taps as two hex digits per row on a VGA raster,
// snapshotting once per frame and highlighting bytes that changed.
module vga_mem_display
    import vga_pkg::*;
#(
    parameter int N_BYTES = 21,
    parameter int ORG_X   = 16,
    parameter int ORG_Y   = 16,
    parameter int HVIS    = H_VIS,
    parameter int HFP     = H_FP,
    parameter int HSYNC   = H_SYNC,
    parameter int HBP     = H_BP,
    parameter int VVIS    = V_VIS,
    parameter int VFP     = V_FP,
    parameter int VSYNC   = V_SYNC,
    parameter int VBP     = V_BP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_ce,
    input  logic [8*N_BYTES-1:0]   mem_bytes,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   frame_start
);

    localparam logic [9:0] H_LAST = 10'(HVIS + HFP + HSYNC + HBP - 1);
    localparam logic [9:0] V_LAST = 10'(VVIS + VFP + VSYNC + VBP - 1);
    localparam logic [9:0] HS_BEG = 10'(HVIS + HFP);
    localparam logic [9:0] HS_END = 10'(HVIS + HFP + HSYNC);
    localparam logic [9:0] VS_BEG = 10'(VVIS + VFP);
    localparam logic [9:0] VS_END = 10'(VVIS + VFP + VSYNC);
    localparam int         CSH    = $clog2(CELL);

    logic [9:0]             hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [8*N_BYTES-1:0]   snap_q, prev_q;
    logic [N_BYTES-1:0]     chg_w;
    logic                   snap_tick;
    logic [9:0]             dx, dy, row_w;
    logic                   in_cell_w, vis_w, hs_w, vs_w, chg_sel;
    logic [7:0]             byte_sel, rom_bits;
    logic [3:0]             nib_w;
    logic [2:0]             gcol_q;
    logic                   cell_q, chg1_q, vis1_q, hs1_q, vs1_q;
    logic                   hs_q, vs_q, blank_n_q;
    logic [23:0]            rgb_q, rgb_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    // Snapshot on the first pixel of the first blanking line.
    assign snap_tick   = (hcnt_q == '0) && (vcnt_q == 10'(VVIS));
    assign frame_start = pix_ce & snap_tick & ~rst;

    always_comb begin
        for (int k = 0; k < N_BYTES; k++)
            chg_w[k] = snap_q[8*k +: 8] != prev_q[8*k +: 8];
    end

    // Offsets wrap above/left of the origin, so a single unsigned compare
    // rejects both sides of the digit area.
    assign dx        = hcnt_q - 10'(ORG_X);
    assign dy        = vcnt_q - 10'(ORG_Y);
    assign row_w     = dy >> CSH;
    assign in_cell_w = (dx < 10'(2*CELL)) && (row_w < 10'(N_BYTES));
    assign vis_w     = (hcnt_q < 10'(HVIS)) && (vcnt_q < 10'(VVIS));
    assign hs_w      = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    assign vs_w      = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

    always_comb begin
        byte_sel = '0;
        chg_sel  = 1'b0;
        for (int k = 0; k < N_BYTES; k++) begin
            if (row_w == 10'(k)) begin
                byte_sel = snap_q[8*k +: 8];
                chg_sel  = chg_w[k];
            end
        end
    end

    assign nib_w = dx[4] ? byte_sel[3:0] : byte_sel[7:4];

    hex_font_rom u_rom (
        .clk_i  (clk),
        .rst_i  (rst),
        .ce_i   (pix_ce),
        .nib_i  (nib_w),
        .row_i  (dy[3:1]),
        .bits_o (rom_bits)
    );

    always_comb begin
        rgb_d = '0;
        if (vis1_q) begin
            rgb_d = COL_BG;
            if (cell_q && rom_bits[~gcol_q])
                rgb_d = chg1_q ? COL_YELLOW : COL_WHITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            snap_q    <= '0;
            prev_q    <= '0;
            gcol_q    <= '0;
            cell_q    <= 1'b0;
            chg1_q    <= 1'b0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else if (pix_ce) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (snap_tick) begin
                prev_q <= snap_q;
                snap_q <= mem_bytes;
            end
            gcol_q    <= dx[3:1];
            cell_q    <= in_cell_w;
            chg1_q    <= chg_sel;
            vis1_q    <= vis_w;
            hs1_q     <= hs_w;
            vs1_q     <= vs_w;
            hs_q      <= hs1_q;
            vs_q      <= vs1_q;
            blank_n_q <= vis1_q;
            rgb_q     <= rgb_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_mem_display.sv
// Directed bench: a reduced-raster instance for glyph/snapshot behaviour and a
// full 640x480 instance for the standard horizontal timing.
module tb_vga_mem_display;

    localparam int NB = 4;
    localparam int HT = 80;
    localparam int VT = 96;
    localparam int FR = HT * VT;
    localparam int SNAP_POS = 88 * HT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b1;
    logic [8*NB-1:0] mem = '0;
    logic [8*21-1:0] mem_full = '0;

    logic vga_hs, vga_vs, vga_blank_n, fs;
    logic [7:0] vga_r, vga_g, vga_b;
    logic f_hs, f_vs, f_blank_n, f_fs;
    logic [7:0] f_r, f_g, f_b;

    always #5 clk = ~clk;

    vga_mem_display #(
        .N_BYTES(NB), .ORG_X(16), .ORG_Y(16),
        .HVIS(64), .HFP(4), .HSYNC(8), .HBP(4),
        .VVIS(88), .VFP(2), .VSYNC(2), .VBP(4)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .mem_bytes(mem),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(fs)
    );

    vga_mem_display dut_full (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .mem_bytes(mem_full),
        .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_blank_n),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .frame_start(f_fs)
    );

    logic [63:0] FONT [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00,
        64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000,
        64'h3C66663C66663C00, 64'h3C66663E060C3800,
        64'h183C66667E666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800,
        64'h7E60607C60607E00, 64'h7E60607C60606000
    };

    int checks = 0;
    int failures = 0;
    int pos = 0;
    int got_fs = 0;
    logic [7:0] msnap [NB];
    logic [7:0] mprev [NB];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NB; k++) begin
            msnap[k] = 8'h00;
            mprev[k] = 8'h00;
        end
    endtask

    // One pix_ce tick; pos is the counter value the DUT holds after the edge.
    task automatic tick();
        @(posedge clk);
        if (pix_ce && pos == SNAP_POS) begin
            for (int k = 0; k < NB; k++) begin
                mprev[k] = msnap[k];
                msnap[k] = mem[8*k +: 8];
            end
        end
        pos = (pos + 1) % FR;
        #1;
        if (fs === 1'b1) begin
            got_fs++;
            chk("frame_start_pos", pos, SNAP_POS);
        end
    endtask

    // Outputs trail the counters by two ticks.
    task automatic see(input int x, input int y);
        int tgt;
        tgt = (y * HT + x + 2) % FR;
        while (pos != tgt) tick();
    endtask

    function automatic logic [23:0] exp_px(input int x, input int y);
        int r, gr, gc;
        logic [7:0] b;
        logic [3:0] nib;
        logic [63:0] g;
        if (x >= 64 || y >= 88) return 24'h000000;
        if (x >= 16 && x < 48 && y >= 16 && y < 80) begin
            r   = (y - 16) / 16;
            b   = msnap[r];
            nib = (x < 32) ? b[7:4] : b[3:0];
            gr  = ((y - 16) % 16) / 2;
            gc  = ((x - 16) % 16) / 2;
            g   = FONT[nib];
            if (g[63 - 8*gr - gc])
                return (msnap[r] != mprev[r]) ? 24'hFFFF00 : 24'hFFFFFF;
        end
        return 24'h000040;
    endfunction

    task automatic chk_px(input int x, input int y);
        see(x, y);
        chk($sformatf("rgb@%0d,%0d", x, y), {8'h00, vga_r, vga_g, vga_b}, exp_px(x, y));
        chk($sformatf("blank@%0d,%0d", x, y), vga_blank_n, (x < 64 && y < 88));
        chk($sformatf("hs@%0d,%0d", x, y), vga_hs, !(x >= 68 && x < 76));
    endtask

    task automatic chk_row(input int r);
        for (int y = 16 + 16*r; y < 32 + 16*r; y++)
            for (int x = 16; x < 48; x++)
                chk_px(x, y);
    endtask

    task automatic measure_vs();
        int n;
        n = 0;
        while (vga_vs !== 1'b0 && n < FR + 10) begin tick(); n++; end
        chk("vs_fall_pos", pos, 90*HT + 2);
        n = 0;
        while (vga_vs === 1'b0 && n < FR) begin tick(); n++; end
        chk("vs_low_ticks", n, 2*HT);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"}, vga_hs, 1);
        chk({tag, "_vs"}, vga_vs, 1);
        chk({tag, "_blank"}, vga_blank_n, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_fs"}, fs, 0);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("full_rst_hs", f_hs, 1);
        chk("full_rst_vs", f_vs, 1);
        chk("full_rst_blank", f_blank_n, 0);
        chk("full_rst_rgb", {f_r, f_g, f_b}, 0);
        chk("full_rst_fs", f_fs, 0);
        rst = 1'b0;
        pos = 0;
        mem[7:0] = 8'hA5;

        // Full-size horizontal timing
        n = 0;
        while (f_hs !== 1'b0 && n < 2000) begin tick(); n++; end
        chk("hs_first_fall", n, 658);
        n = 0;
        while (f_hs === 1'b0 && n < 2000) begin tick(); n++; end
        chk("hs_low_ticks", n, 96);
        while (f_hs !== 1'b0 && n < 2000) begin tick(); n++; end
        chk("hs_period", n, 800);

        // Frame 0: empty snapshot
        chk_row(1);
        measure_vs();

        // Frame 1: A5 freshly changed -> yellow
        chk_px(8, 10);
        chk_row(0);
        chk_row(1);
        chk_px(50, 82);
        chk_px(30, 84);
        chk_px(70, 85);
        measure_vs();

        // Frame 2: A5 stable -> white; byte3 changes mid-frame, not yet visible
        chk_row(0);
        see(0, 40);
        mem[31:24] = 8'h7E;
        chk_row(3);
        measure_vs();

        // Frame 3: pix_ce gating mid-line, then 7E in yellow
        see(25, 20);
        pix_ce = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("gate_rgb", {vga_r, vga_g, vga_b}, exp_px(25, 20));
        chk("gate_blank", vga_blank_n, 1);
        chk("gate_hs", vga_hs, 1);
        pix_ce = 1'b1;
        tick();
        chk_px(26, 20);
        chk_row(3);

        // Frame 4: reset at line 50 with pix_ce low
        see(0, 50);
        rst = 1'b1;
        pix_ce = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        pix_ce = 1'b1;
        pos = 0;
        model_clear();
        mem = '0;
        mem[23:16] = 8'hC3;

        chk_row(0);
        chk_row(2);
        chk_row(0);
        chk_row(2);

        chk("frame_start_count", got_fs, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_mem_display.md
# vga_mem_display

Read-only VGA renderer for the data-memory debug window. Consumes the 21 byte taps that data memory exports (bytes 0–20) and draws each one as two hex digits on a 640×480@60 Hz screen. Memory contents are snapshotted once per frame so each frame shows a coherent image. Bytes whose value changed since the previous snapshot are highlighted for one frame.

## Interface
Parameters:
- `N_BYTES`, 21: number of memory byte taps displayed; one text row each.
- `ORG_X`, 16: left pixel column of the digit area.
- `ORG_Y`, 16: top pixel line of the digit area.

Ports:
- `clk`  in  1: system clock; the single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `pix_ce`  in  1: pixel-clock enable (25 MHz rate). All state advances only when high.
- `mem_bytes`  in  8*N_BYTES: byte k at bits [8k+7:8k]; driven from data memory taps 0–20.
- `vga_hs`  out  1: horizontal sync, active low.
- `vga_vs`  out  1: vertical sync, active low.
- `vga_blank_n`  out  1: high in the visible area.
- `vga_r`, `vga_g`, `vga_b`  out  8 each: pixel colour.
- `frame_start`  out  1: one-`clk` pulse on the `pix_ce` tick where the snapshot is taken.

## Operation
- Counters:
  - `hcnt` runs 0..799. It advances on each `pix_ce`.
  - `vcnt` runs 0..524. It advances when `hcnt` wraps from 799 to 0.
  - `vcnt` wraps from 524 to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Snapshot:
  - Taken on the `pix_ce` tick where `hcnt`=0 and `vcnt`=480 (first blanking line).
  - `prev` ← `snap`, then `snap` ← `mem_bytes`. Both transfers happen in the same tick.
  - `chg[k]` = (`snap[k]` != `prev[k]`), evaluated on the new values.
  - `frame_start` pulses high on that tick.
- Rendering:
  - Cells are 16×16 px: an 8×8 glyph scaled ×2.
  - Row k (0..N_BYTES-1) occupies lines ORG_Y+16k .. ORG_Y+16k+15.
  - High nibble is drawn at columns ORG_X..ORG_X+15; low nibble at ORG_X+16..ORG_X+31.
  - Glyph row = (line offset)>>1. Glyph column = (pixel offset)>>1, MSB = leftmost pixel.
  - Pixel on glyph bit = 1: white FFFFFF if `chg[k]`=0, yellow FFFF00 if `chg[k]`=1.
  - Any other visible pixel: background 000040.
  - Blanking: RGB = 000000 and `vga_blank_n`=0.
- Width rules:
  - `hcnt` is 10 bits, `vcnt` is 10 bits.
  - Row index = (vcnt−ORG_Y)>>4, valid only if < N_BYTES. Compares use unsigned arithmetic.
- Pipeline:
  - Stage 1: decode cell and nibble, and register the font ROM address.
  - Stage 2: ROM data and colour select.
  - Sync and blank signals are delayed by 2 `pix_ce` ticks so they stay aligned with RGB.
- Reset, including mid-frame:
  - `hcnt`=`vcnt`=0.
  - Pipeline cleared, `snap`=`prev`=0, `chg`=0.
  - Outputs return to reset values on the next `clk` edge regardless of `pix_ce`.
- `pix_ce`=0: all registers hold, outputs hold.

## Timing
- Reset values: `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, RGB=0, `frame_start`=0.
- Latency from counter value to outputs: exactly 2 `pix_ce` ticks, for colour and sync alike.
- `vga_hs` is low for 96 consecutive ticks per line. `vga_vs` is low for 2 full lines (1600 ticks).
- Frame length: 420 000 `pix_ce` ticks.
- `mem_bytes` changes between snapshots have no visible effect until the next snapshot.
- A change on the snapshot tick itself is captured if it is stable at that `clk` edge.

## Structure
- Package `vga_pkg` holds:
  - Horizontal and vertical timing constants (visible, front porch, sync, back porch, totals).
  - Colour constants (white, yellow, background).
  - Cell size of 16.
- Sub-module `hex_font_rom`:
  - Inputs: 4-bit nibble and 3-bit glyph row.
  - Output: 8-bit registered row bits.
  - 16 glyphs, 0–F; one read per `pix_ce`.
- The top holds the counters, the snapshot/compare registers, cell decode and delay lines.

## Test plan
- Reset: assert `rst` for 3 cycles with `pix_ce`=1.
  - Expect `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, RGB=0.
  - After release, first `vga_hs` fall exactly 656+2 ticks later.
- Sync timing over 2 frames: `vga_hs` period 800 ticks with 96 low; `vga_vs` period 420 000 ticks with 1600 low; `frame_start` once per frame.
- Glyph check with `mem_bytes` byte0 = A5, all others 00, after one snapshot:
  - Pixels of row 0 at columns 16..31 match the glyph 'A' ×2.
  - Columns 32..47 match '5'.
  - Row 1 shows "00".
  - Colour is yellow in frame 1, since the byte changed from 0; white in frame 2.
- Snapshot isolation: set byte3 = 7E at mid-frame (`vcnt`=200).
  - Row 3 is unchanged until the `vcnt`=480 snapshot.
  - Next frame shows "7E" in yellow.
- `pix_ce` gating: hold `pix_ce`=0 for 50 cycles mid-line; counters and all outputs hold.
- Mid-frame reset at `vcnt`=300:
  - Outputs return to reset values.
  - `snap` is cleared, so the display shows "00" rows after the next snapshot unless memory is nonzero.
